ball_engine: RTL and testbench

//  Game-logic stage directly upstream of the VGA renderer: owns the ball position on the 32x32

---
 rtl/ball_engine.sv | 175 +++++++++++++++++
 tb/tb_ball_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Ball position and rally state for the 32x32 playfield. Advances on vsync-derived
// frame strobes, bounces off the top and bottom rows and the paddles, and flags misses.
module ball_engine #(
    parameter int unsigned STEP_FRAMES  = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MISS_FRAMES  = 30,
    parameter bit          VSYNC_NEG    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic [31:0] lpaddle,
    input  logic [31:0] rpaddle,
    output logic [4:0]  ball_x,
    output logic [4:0]  ball_y,
    output logic        lscore,
    output logic        rscore,
    output logic        in_play,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
    localparam logic [4:0] CENTRE     = 5'd15;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  x_q;
    logic [4:0]  y_q;
    logic        dx_q;
    logic        dy_q;
    logic        vsync_q;
    logic        lscore_q;
    logic        rscore_q;
    logic        in_play_q;

    logic        strobe;
    logic [4:0]  x_d;
    logic [4:0]  y_d;
    logic        dx_d;
    logic        dy_d;
    logic        miss_l_d;
    logic        miss_r_d;

    // Frame strobe: registered vsync differs from the live level in the active direction.
    assign strobe = VSYNC_NEG ? (vsync_q & ~vsync) : (~vsync_q & vsync);

    // One ball step computed from the current registered position and direction.
    // The paddle test uses the post-bounce row so a corner hit behaves consistently.
    always_comb begin
        y_d      = y_q;
        dy_d     = dy_q;
        x_d      = x_q;
        dx_d     = dx_q;
        miss_l_d = 1'b0;
        miss_r_d = 1'b0;

        if (dy_q && (y_q == 5'd31)) begin
            dy_d = 1'b0;
            y_d  = 5'd30;
        end else if (!dy_q && (y_q == 5'd0)) begin
            dy_d = 1'b1;
            y_d  = 5'd1;
        end else if (dy_q) begin
            y_d = y_q + 5'd1;
        end else begin
            y_d = y_q - 5'd1;
        end

        if (dx_q && (x_q == 5'd30)) begin
            if (lpaddle[y_d]) begin
                dx_d = 1'b0;
                x_d  = 5'd29;
            end else begin
                x_d      = 5'd31;
                miss_r_d = 1'b1;
            end
        end else if (!dx_q && (x_q == 5'd1)) begin
            if (rpaddle[y_d]) begin
                dx_d = 1'b1;
                x_d  = 5'd2;
            end else begin
                x_d      = 5'd0;
                miss_l_d = 1'b1;
            end
        end else if (dx_q) begin
            x_d = x_q + 5'd1;
        end else begin
            x_d = x_q - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SERVE;
            cnt_q     <= 8'd0;
            x_q       <= CENTRE;
            y_q       <= CENTRE;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            vsync_q   <= VSYNC_NEG;
            lscore_q  <= 1'b0;
            rscore_q  <= 1'b0;
            in_play_q <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            lscore_q <= 1'b0;
            rscore_q <= 1'b0;
            if (strobe) begin
                case (state_q)
                    ST_SERVE: begin
                        x_q <= CENTRE;
                        y_q <= CENTRE;
                        if (cnt_q == SERVE_LAST) begin
                            cnt_q     <= 8'd0;
                            state_q   <= ST_PLAY;
                            in_play_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_PLAY: begin
                        if (cnt_q == STEP_LAST) begin
                            cnt_q <= 8'd0;
                            x_q   <= x_d;
                            y_q   <= y_d;
                            dx_q  <= dx_d;
                            dy_q  <= dy_d;
                            if (miss_l_d || miss_r_d) begin
                                state_q   <= ST_MISS;
                                in_play_q <= 1'b0;
                                lscore_q  <= miss_l_d;
                                rscore_q  <= miss_r_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_MISS: begin
                        // dx is kept so the serve heads toward the player who missed.
                        if (cnt_q == MISS_LAST) begin
                            cnt_q   <= 8'd0;
                            state_q <= ST_SERVE;
                            x_q     <= CENTRE;
                            y_q     <= CENTRE;
                            dy_q    <= ~dy_q;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q   <= ST_SERVE;
                        cnt_q     <= 8'd0;
                        in_play_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ball_x  = x_q;
    assign ball_y  = y_q;
    assign lscore  = lscore_q;
    assign rscore  = rscore_q;
    assign in_play = in_play_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: a falling-edge vsync instance drives the rally scenarios,
// a second rising-edge instance checks vsync polarity handling.
module tb_ball_engine;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        vsync2;
    logic [31:0] lpaddle;
    logic [31:0] rpaddle;
    logic [4:0]  ball_x, ball_y, ball_x2, ball_y2;
    logic        lscore, rscore, in_play, lscore2, rscore2, in_play2;
    logic [1:0]  state_o, state_o2;

    int total = 0;
    int bad   = 0;
    int l_cnt = 0;
    int r_cnt = 0;
    int l_base, r_base;

    localparam logic [1:0] SERVE = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] MISS  = 2'd2;

    ball_engine #(.STEP_FRAMES(1), .SERVE_FRAMES(60), .MISS_FRAMES(30), .VSYNC_NEG(1'b1)) u_dut (
        .clk(clk), .reset(reset), .vsync(vsync), .lpaddle(lpaddle), .rpaddle(rpaddle),
        .ball_x(ball_x), .ball_y(ball_y), .lscore(lscore), .rscore(rscore),
        .in_play(in_play), .state_o(state_o)
    );

    ball_engine #(.STEP_FRAMES(2), .SERVE_FRAMES(2), .MISS_FRAMES(2), .VSYNC_NEG(1'b0)) u_pos (
        .clk(clk), .reset(reset), .vsync(vsync2), .lpaddle(lpaddle), .rpaddle(rpaddle),
        .ball_x(ball_x2), .ball_y(ball_y2), .lscore(lscore2), .rscore(rscore2),
        .in_play(in_play2), .state_o(state_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lscore === 1'b1) l_cnt++;
        if (rscore === 1'b1) r_cnt++;
    end

    task automatic vsync_fall();
        @(negedge clk) vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic vsync_rise();
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_fall();
            vsync_rise();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ball_x, ball_y} !== {5'd15, 5'd15}) begin
            $display("FAIL reset_pos: got (%0d,%0d) want (15,15)", ball_x, ball_y); bad++;
        end
        total++;
        if ({in_play, lscore, rscore, state_o} !== {3'b000, SERVE}) begin
            $display("FAIL reset_flags: got play=%b l=%b r=%b st=%0d want 0 0 0 0",
                     in_play, lscore, rscore, state_o); bad++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_serve();
        frames(59);
        total++;
        if ({ball_x, ball_y, in_play} !== {5'd15, 5'd15, 1'b0}) begin
            $display("FAIL serve_59: got (%0d,%0d) play=%b want (15,15) play=0",
                     ball_x, ball_y, in_play); bad++;
        end
        frames(1);
        total++;
        if ({ball_x, ball_y, in_play, state_o} !== {5'd15, 5'd15, 1'b1, PLAY}) begin
            $display("FAIL serve_60: got (%0d,%0d) play=%b st=%0d want (15,15) play=1 st=1",
                     ball_x, ball_y, in_play, state_o); bad++;
        end
    endtask

    task automatic test_bounce();
        lpaddle = 32'hFFFF_FFFF;
        frames(15);
        total++;
        if ({ball_x, ball_y} !== {5'd30, 5'd30}) begin
            $display("FAIL bounce_diag: got (%0d,%0d) want (30,30)", ball_x, ball_y); bad++;
        end
        frames(1);
        total++;
        if ({ball_x, ball_y} !== {5'd29, 5'd31}) begin
            $display("FAIL bounce_paddle: got (%0d,%0d) want (29,31)", ball_x, ball_y); bad++;
        end
        frames(1);
        total++;
        if ({ball_x, ball_y} !== {5'd28, 5'd30}) begin
            $display("FAIL bounce_top: got (%0d,%0d) want (28,30)", ball_x, ball_y); bad++;
        end
    endtask

    task automatic test_paddle_hit();
        frames(27);
        total++;
        if ({ball_x, ball_y} !== {5'd1, 5'd3}) begin
            $display("FAIL hit_approach: got (%0d,%0d) want (1,3)", ball_x, ball_y); bad++;
        end
        l_base  = l_cnt;
        rpaddle = 32'h0000_0004;
        frames(1);
        total++;
        if ({ball_x, ball_y, in_play} !== {5'd2, 5'd2, 1'b1} || l_cnt != l_base) begin
            $display("FAIL hit_rpaddle: got (%0d,%0d) play=%b lpulses=%0d want (2,2) play=1 lpulses=0",
                     ball_x, ball_y, in_play, l_cnt - l_base); bad++;
        end
    endtask

    task automatic test_miss();
        lpaddle = 32'h0;
        frames(28);
        total++;
        if ({ball_x, ball_y} !== {5'd30, 5'd26}) begin
            $display("FAIL miss_approach: got (%0d,%0d) want (30,26)", ball_x, ball_y); bad++;
        end
        r_base = r_cnt;
        vsync_fall();
        total++;
        if ({ball_x, ball_y, rscore, in_play, state_o} !== {5'd31, 5'd27, 1'b1, 1'b0, MISS}) begin
            $display("FAIL miss_step: got (%0d,%0d) r=%b play=%b st=%0d want (31,27) r=1 play=0 st=2",
                     ball_x, ball_y, rscore, in_play, state_o); bad++;
        end
        @(negedge clk);
        total++;
        if (rscore !== 1'b0) begin
            $display("FAIL miss_pulse_width: got rscore=%b want 0", rscore); bad++;
        end
        vsync_rise();
        total++;
        if (r_cnt - r_base != 1 || lscore !== 1'b0) begin
            $display("FAIL miss_pulse_count: got %0d rscore cycles want 1", r_cnt - r_base); bad++;
        end
        frames(29);
        total++;
        if ({ball_x, ball_y, state_o} !== {5'd31, 5'd27, MISS}) begin
            $display("FAIL miss_hold: got (%0d,%0d) st=%0d want (31,27) st=2", ball_x, ball_y, state_o); bad++;
        end
        frames(1);
        total++;
        if ({ball_x, ball_y, state_o, in_play} !== {5'd15, 5'd15, SERVE, 1'b0}) begin
            $display("FAIL miss_reserve: got (%0d,%0d) st=%0d play=%b want (15,15) st=0 play=0",
                     ball_x, ball_y, state_o, in_play); bad++;
        end
    endtask

    // Serve after the miss heads +x with dy flipped to 0; the bottom bounce at x=30
    // must test row 1, so a paddle covering only row 0 misses.
    task automatic test_corner_miss();
        frames(60);
        frames(15);
        total++;
        if ({ball_x, ball_y, in_play} !== {5'd30, 5'd0, 1'b1}) begin
            $display("FAIL corner_approach: got (%0d,%0d) play=%b want (30,0) play=1",
                     ball_x, ball_y, in_play); bad++;
        end
        lpaddle = 32'h0000_0001;
        r_base  = r_cnt;
        frames(1);
        total++;
        if ({ball_x, ball_y, state_o} !== {5'd31, 5'd1, MISS} || r_cnt - r_base != 1) begin
            $display("FAIL corner_miss: got (%0d,%0d) st=%0d rpulses=%0d want (31,1) st=2 rpulses=1",
                     ball_x, ball_y, state_o, r_cnt - r_base); bad++;
        end
        frames(5);
    endtask

    task automatic test_reset_mid_miss();
        l_base = l_cnt;
        r_base = r_cnt;
        @(negedge clk) reset = 1'b1;
        #1;
        total++;
        if ({ball_x, ball_y, in_play, state_o, lscore, rscore} !== {5'd15, 5'd15, 1'b0, SERVE, 2'b00}) begin
            $display("FAIL reset_async: got (%0d,%0d) play=%b st=%0d l=%b r=%b want (15,15) 0 0 0 0",
                     ball_x, ball_y, in_play, state_o, lscore, rscore); bad++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (l_cnt != l_base || r_cnt != r_base) begin
            $display("FAIL reset_no_pulse: got l=%0d r=%0d pulses want 0 0",
                     l_cnt - l_base, r_cnt - r_base); bad++;
        end
    endtask

    task automatic test_vsync_idle();
        lpaddle = 32'hFFFF_FFFF;
        rpaddle = 32'hFFFF_FFFF;
        frames(60);
        repeat (10000) @(negedge clk);
        total++;
        if ({ball_x, ball_y, in_play} !== {5'd15, 5'd15, 1'b1}) begin
            $display("FAIL vsync_idle: got (%0d,%0d) play=%b want (15,15) play=1",
                     ball_x, ball_y, in_play); bad++;
        end
        frames(1);
        total++;
        if ({ball_x, ball_y} !== {5'd16, 5'd16}) begin
            $display("FAIL vsync_resume: got (%0d,%0d) want (16,16)", ball_x, ball_y); bad++;
        end
    endtask

    task automatic test_pos_polarity();
        @(negedge clk) reset = 1'b1;
        vsync2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) vsync2 = 1'b1;
            @(negedge clk);
            if (i == 1) begin
                total++;
                if ({in_play2, state_o2} !== {1'b1, PLAY}) begin
                    $display("FAIL pos_serve_on_rise: got play=%b st=%0d want 1 1", in_play2, state_o2); bad++;
                end
            end
            repeat (3) @(negedge clk);
            vsync2 = 1'b0;
            repeat (3) @(negedge clk);
        end
        @(negedge clk) vsync2 = 1'b1;
        repeat (4) @(negedge clk);
        vsync2 = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({ball_x2, ball_y2} !== {5'd15, 5'd15}) begin
            $display("FAIL pos_count: got (%0d,%0d) want (15,15)", ball_x2, ball_y2); bad++;
        end
        @(negedge clk) vsync2 = 1'b1;
        @(negedge clk);
        total++;
        if ({ball_x2, ball_y2} !== {5'd16, 5'd16}) begin
            $display("FAIL pos_step_on_rise: got (%0d,%0d) want (16,16)", ball_x2, ball_y2); bad++;
        end
        repeat (3) @(negedge clk);
        vsync2 = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if ({ball_x2, ball_y2, in_play2} !== {5'd16, 5'd16, 1'b1}) begin
            $display("FAIL pos_fall_ignored: got (%0d,%0d) play=%b want (16,16) play=1",
                     ball_x2, ball_y2, in_play2); bad++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        vsync   = 1'b1;
        vsync2  = 1'b0;
        lpaddle = 32'h0;
        rpaddle = 32'hFFFF_FFFF;
        test_reset();
        test_serve();
        test_bounce();
        test_paddle_hit();
        test_miss();
        test_corner_miss();
        test_reset_mid_miss();
        test_vsync_idle();
        test_pos_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
